// File: rtl/led_sched.sv
// Purpose: two-requester round-robin LED pattern player; a granted job plays
//          (rep+1) A/B cycles, each phase holding led for HALF_PERIOD clocks.
// Latency/backpressure: grant one edge after a request is seen in IDLE; requests
//          are simply left pending while busy, abort kills a job on the next edge.
// Ports: clk/rst_n (async active-low); req[1:0] level requests; pat0/pat1
//        {phaseB,phaseA} LED values; rep0/rep1 repeat counts; abort cancel;
//        gnt one-hot grant pulse; owner current/last job index; busy while
//        playing; done normal-completion pulse; led registered LED drive.
module led_sched #(
  parameter int unsigned HALF_PERIOD = 200_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] pat0,
  input  logic [3:0] pat1,
  input  logic [7:0] rep0,
  input  logic [7:0] rep1,
  input  logic       abort,
  output logic [1:0] gnt,
  output logic       owner,
  output logic       busy,
  output logic       done,
  output logic [1:0] led
);

  typedef enum logic [1:0] {IDLE, PH_A, PH_B} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       pat_q;
  logic [7:0]       rem_q;
  logic             prio_q;   // requester that wins a simultaneous request
  logic [1:0]       gnt_q;
  logic             owner_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       led_q;

  // Arbitration winner and its job parameters, evaluated only in IDLE.
  logic       pick_d;
  logic [3:0] sel_pat_d;
  logic [7:0] sel_rep_d;
  logic       last_d;

  always_comb begin
    pick_d    = 1'b0;
    if (req == 2'b11) pick_d = prio_q;
    else              pick_d = req[1];
    sel_pat_d = pick_d ? pat1 : pat0;
    sel_rep_d = pick_d ? rep1 : rep0;
    last_d    = (cnt_q == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      prio_q  <= 1'b0;
      gnt_q   <= 2'b00;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 2'b00;
    end else begin
      // Both pulses default low so each lasts exactly one cycle.
      gnt_q  <= 2'b00;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= pick_d ? 2'b10 : 2'b01;
            owner_q <= pick_d;
            prio_q  <= ~pick_d;
            pat_q   <= sel_pat_d;
            rem_q   <= sel_rep_d;
            cnt_q   <= '0;
            led_q   <= sel_pat_d[1:0];
            busy_q  <= 1'b1;
            state_q <= PH_A;
          end
        end
        PH_A: begin
          if (abort) begin
            state_q <= IDLE;
            led_q   <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (last_d) begin
            cnt_q   <= '0;
            led_q   <= pat_q[3:2];
            state_q <= PH_B;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PH_B: begin
          // Abort takes precedence over the final edge, so no done pulse.
          if (abort) begin
            state_q <= IDLE;
            led_q   <= 2'b00;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (last_d) begin
            cnt_q <= '0;
            if (rem_q != 8'd0) begin
              rem_q   <= rem_q - 8'd1;
              led_q   <= pat_q[1:0];
              state_q <= PH_A;
            end else begin
              led_q   <= 2'b00;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          led_q   <= 2'b00;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign led   = led_q;

endmodule
